// File: rtl/mnacidpro_pkg.sv
// Shared types and constants for the mnacidpro valve sequencer: step states,
// valve bit positions, per-step open-valve masks and the peristaltic pattern.
package mnacidpro_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEAD_LOAD,
    ST_LYSIS,
    ST_WASH,
    ST_ELUTE,
    ST_COLLECT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SUB_SETTLE,
    SUB_PUMP,
    SUB_FLUSH
  } sub_t;

  localparam int NUM_VALVES   = 11;
  localparam int V_LYSIS      = 0;
  localparam int V_WASH       = 1;
  localparam int V_ELUTE      = 2;
  localparam int V_DEAD_END   = 3;
  localparam int V_VERTICAL   = 4;
  localparam int V_HORIZ      = 5;
  localparam int V_WASTE      = 6;
  localparam int V_BEAD       = 7;
  localparam int V_LOOP_EXIT  = 8;
  localparam int V_BEAD_TRAP  = 9;
  localparam int V_COLLECT    = 10;

  localparam logic [2:0] PUMP_CLOSED = 3'b111;

  // Gray-like sequence: neighbouring phases differ in a single valve.
  localparam logic [2:0] PUMP_PAT [6] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};

  // 1 marks a valve that is open (depressurised) during the given step.
  function automatic logic [NUM_VALVES-1:0] valve_open_mask(state_t s);
    logic [NUM_VALVES-1:0] m;
    m = '0;
    case (s)
      ST_BEAD_LOAD: begin
        m[V_BEAD]  = 1'b1;
        m[V_HORIZ] = 1'b1;
        m[V_WASTE] = 1'b1;
      end
      ST_LYSIS: begin
        m[V_LYSIS]     = 1'b1;
        m[V_VERTICAL]  = 1'b1;
        m[V_LOOP_EXIT] = 1'b1;
        m[V_WASTE]     = 1'b1;
      end
      ST_WASH: begin
        m[V_WASH]  = 1'b1;
        m[V_HORIZ] = 1'b1;
        m[V_WASTE] = 1'b1;
      end
      ST_ELUTE: begin
        m[V_ELUTE]    = 1'b1;
        m[V_VERTICAL] = 1'b1;
        m[V_DEAD_END] = 1'b1;
      end
      ST_COLLECT: begin
        m[V_BEAD_TRAP] = 1'b1;
        m[V_LOOP_EXIT] = 1'b1;
        m[V_COLLECT]   = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mnacidpro_valve_seq_pump.sv
// Peristaltic pump pattern generator: while enable is high, the registered
// pump output steps P0..P5, each held PUMP_HOLD cycles, for STROKES strokes.
module peristaltic_pump_gen
  import mnacidpro_pkg::*;
#(
  parameter int PUMP_HOLD = 4,
  parameter int STROKES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic [2:0] pump,
  output logic       strokes_done
);

  localparam int HOLD_W   = $clog2(PUMP_HOLD + 1);
  localparam int STROKE_W = $clog2(STROKES + 1);

  logic [HOLD_W-1:0]   hold_cnt;
  logic [2:0]          phase;
  logic [STROKE_W-1:0] stroke;
  logic                hold_last;
  logic                phase_last;
  logic                stroke_last;

  assign hold_last   = (hold_cnt == HOLD_W'(PUMP_HOLD - 1));
  assign phase_last  = (phase == 3'd5);
  assign stroke_last = (stroke == STROKE_W'(STROKES - 1));

  // enable describes the next cycle, so the pattern lands on the pump outputs
  // exactly in the cycles the sequencer has scheduled for pumping.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      hold_cnt     <= '0;
      phase        <= '0;
      stroke       <= '0;
      pump         <= PUMP_CLOSED;
      strokes_done <= 1'b0;
    end else begin
      pump         <= PUMP_PAT[phase];
      strokes_done <= hold_last && phase_last && stroke_last;
      if (hold_last) begin
        hold_cnt <= '0;
        if (phase_last) begin
          phase  <= '0;
          stroke <= stroke_last ? '0 : stroke + STROKE_W'(1);
        end else begin
          phase <= phase + 3'd1;
        end
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

endmodule

// File: rtl/mnacidpro_valve_seq.sv
// Protocol sequencer for the mnacidpro control layer (bead-load/lysis/wash/
// elute/collect per sample). Define MNACID_FLUSH_EN for the per-step flush.
module mnacidpro_valve_seq
  import mnacidpro_pkg::*;
#(
  parameter int SIZE         = 8,
  parameter int PUMP_HOLD    = 4,
  parameter int STROKES      = 2,
  parameter int SETTLE       = 2,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [$clog2(SIZE+1)-1:0] n_samples,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(SIZE)-1:0]   sample_idx,
  output logic                      lysis_ctrl,
  output logic                      wash_ctrl,
  output logic                      elute_ctrl,
  output logic                      dead_end_ctrl,
  output logic                      vertical_ctrl,
  output logic                      horiz_ctrl,
  output logic                      waste_ctrl,
  output logic                      bead_ctrl,
  output logic                      loop_exit_ctrl,
  output logic                      bead_trap_ctrl,
  output logic                      collect_ctrl,
  output logic [2:0]                pump
`ifdef MNACID_FLUSH_EN
  ,
  output logic                      lysis_flush,
  output logic                      wash_flush,
  output logic                      elute_flush,
  output logic                      dead_end_flush,
  output logic                      vertical_flush,
  output logic                      horiz_flush,
  output logic                      waste_flush,
  output logic                      bead_flush,
  output logic                      loop_exit_flush,
  output logic                      bead_trap_flush,
  output logic                      collect_flush,
  output logic [2:0]                pump_flush
`endif
);

  localparam int N_W     = $clog2(SIZE + 1);
  localparam int S_W     = $clog2(SIZE);
  localparam int TMR_MAX = (SETTLE > FLUSH_CYCLES) ? SETTLE : FLUSH_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  function automatic logic [N_W-1:0] sat_samples(logic [N_W-1:0] n);
    if (n > N_W'(SIZE)) return N_W'(SIZE);
    return n;
  endfunction

  state_t                state, state_nxt;
  sub_t                  sub, sub_nxt;
  logic [TMR_W-1:0]      tmr, tmr_nxt;
  logic [S_W-1:0]        samp_nxt;
  logic [N_W-1:0]        n_lat, n_nxt;
  logic                  step_end;
  logic                  last_sample;
  logic                  strokes_done;
  logic                  pump_en;
  logic [NUM_VALVES-1:0] valve_q;

  assign last_sample = ((N_W'(sample_idx) + N_W'(1)) == n_lat);
  assign pump_en     = (sub_nxt == SUB_PUMP);

  peristaltic_pump_gen #(
    .PUMP_HOLD(PUMP_HOLD),
    .STROKES  (STROKES)
  ) u_pump (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (pump_en),
    .pump        (pump),
    .strokes_done(strokes_done)
  );

  always_comb begin
    state_nxt = state;
    sub_nxt   = sub;
    tmr_nxt   = tmr;
    samp_nxt  = sample_idx;
    n_nxt     = n_lat;
    step_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        sub_nxt  = SUB_SETTLE;
        tmr_nxt  = '0;
        samp_nxt = '0;
        if (start && !abort) begin
          n_nxt     = sat_samples(n_samples);
          state_nxt = (n_samples == '0) ? ST_DONE : ST_BEAD_LOAD;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        samp_nxt  = '0;
      end
      default: begin
        case (sub)
          SUB_SETTLE: begin
            if (tmr == TMR_W'(SETTLE - 1)) begin
              sub_nxt = SUB_PUMP;
              tmr_nxt = '0;
            end else begin
              tmr_nxt = tmr + TMR_W'(1);
            end
          end
          SUB_PUMP: begin
            if (strokes_done) begin
`ifdef MNACID_FLUSH_EN
              sub_nxt = SUB_FLUSH;
              tmr_nxt = '0;
`else
              step_end = 1'b1;
`endif
            end
          end
          SUB_FLUSH: begin
            if (tmr == TMR_W'(FLUSH_CYCLES - 1)) step_end = 1'b1;
            else tmr_nxt = tmr + TMR_W'(1);
          end
          default: sub_nxt = SUB_SETTLE;
        endcase
        if (step_end) begin
          sub_nxt = SUB_SETTLE;
          tmr_nxt = '0;
          case (state)
            ST_BEAD_LOAD: state_nxt = ST_LYSIS;
            ST_LYSIS:     state_nxt = ST_WASH;
            ST_WASH:      state_nxt = ST_ELUTE;
            ST_ELUTE:     state_nxt = ST_COLLECT;
            default: begin
              if (last_sample) begin
                state_nxt = ST_DONE;
                samp_nxt  = '0;
              end else begin
                state_nxt = ST_BEAD_LOAD;
                samp_nxt  = sample_idx + S_W'(1);
              end
            end
          endcase
        end
        // abort outranks any step advance decided above
        if (abort) begin
          state_nxt = ST_IDLE;
          sub_nxt   = SUB_SETTLE;
          tmr_nxt   = '0;
          samp_nxt  = '0;
        end
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sub        <= SUB_SETTLE;
      tmr        <= '0;
      n_lat      <= '0;
      sample_idx <= '0;
      valve_q    <= '1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      sub        <= sub_nxt;
      tmr        <= tmr_nxt;
      n_lat      <= n_nxt;
      sample_idx <= samp_nxt;
      valve_q    <= ~valve_open_mask(state_nxt);
      busy       <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
      done       <= (state_nxt == ST_DONE);
    end
  end

  assign lysis_ctrl     = valve_q[V_LYSIS];
  assign wash_ctrl      = valve_q[V_WASH];
  assign elute_ctrl     = valve_q[V_ELUTE];
  assign dead_end_ctrl  = valve_q[V_DEAD_END];
  assign vertical_ctrl  = valve_q[V_VERTICAL];
  assign horiz_ctrl     = valve_q[V_HORIZ];
  assign waste_ctrl     = valve_q[V_WASTE];
  assign bead_ctrl      = valve_q[V_BEAD];
  assign loop_exit_ctrl = valve_q[V_LOOP_EXIT];
  assign bead_trap_ctrl = valve_q[V_BEAD_TRAP];
  assign collect_ctrl   = valve_q[V_COLLECT];

`ifdef MNACID_FLUSH_EN
  logic [NUM_VALVES-1:0] flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_q    <= '0;
      pump_flush <= 3'b000;
    end else begin
      flush_q    <= (sub_nxt == SUB_FLUSH) ? valve_open_mask(state_nxt) : '0;
      pump_flush <= (sub_nxt == SUB_FLUSH) ? 3'b111 : 3'b000;
    end
  end

  assign lysis_flush     = flush_q[V_LYSIS];
  assign wash_flush      = flush_q[V_WASH];
  assign elute_flush     = flush_q[V_ELUTE];
  assign dead_end_flush  = flush_q[V_DEAD_END];
  assign vertical_flush  = flush_q[V_VERTICAL];
  assign horiz_flush     = flush_q[V_HORIZ];
  assign waste_flush     = flush_q[V_WASTE];
  assign bead_flush      = flush_q[V_BEAD];
  assign loop_exit_flush = flush_q[V_LOOP_EXIT];
  assign bead_trap_flush = flush_q[V_BEAD_TRAP];
  assign collect_flush   = flush_q[V_COLLECT];
`endif

endmodule

// File: tb/tb_mnacidpro_valve_seq.sv
// Directed self-checking bench for mnacidpro_valve_seq (PUMP_HOLD=2,
// STROKES=1, SETTLE=2); the flush checks build only with MNACID_FLUSH_EN.
module tb_mnacidpro_valve_seq;

  localparam int SIZE         = 8;
  localparam int PUMP_HOLD    = 2;
  localparam int STROKES      = 1;
  localparam int SETTLE       = 2;
  localparam int FLUSH_CYCLES = 3;
  localparam int PUMP_END     = 14;
`ifdef MNACID_FLUSH_EN
  localparam int L = 17;
`else
  localparam int L = 14;
`endif
  localparam logic [10:0] ALL_CLOSED = 11'h7FF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] n_samples;
  logic       busy, done;
  logic [2:0] sample_idx;
  logic       lysis_ctrl, wash_ctrl, elute_ctrl, dead_end_ctrl, vertical_ctrl, horiz_ctrl;
  logic       waste_ctrl, bead_ctrl, loop_exit_ctrl, bead_trap_ctrl, collect_ctrl;
  logic [2:0] pump;
  logic [10:0] ctrl_vec;
`ifdef MNACID_FLUSH_EN
  logic       lysis_flush, wash_flush, elute_flush, dead_end_flush, vertical_flush, horiz_flush;
  logic       waste_flush, bead_flush, loop_exit_flush, bead_trap_flush, collect_flush;
  logic [2:0] pump_flush;
  logic [10:0] flush_vec;
  assign flush_vec = {collect_flush, bead_trap_flush, loop_exit_flush, bead_flush, waste_flush,
                      horiz_flush, vertical_flush, dead_end_flush, elute_flush, wash_flush, lysis_flush};
`endif

  assign ctrl_vec = {collect_ctrl, bead_trap_ctrl, loop_exit_ctrl, bead_ctrl, waste_ctrl,
                     horiz_ctrl, vertical_ctrl, dead_end_ctrl, elute_ctrl, wash_ctrl, lysis_ctrl};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mnacidpro_valve_seq #(
    .SIZE(SIZE), .PUMP_HOLD(PUMP_HOLD), .STROKES(STROKES), .SETTLE(SETTLE),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .n_samples(n_samples),
    .busy(busy), .done(done), .sample_idx(sample_idx),
    .lysis_ctrl(lysis_ctrl), .wash_ctrl(wash_ctrl), .elute_ctrl(elute_ctrl),
    .dead_end_ctrl(dead_end_ctrl), .vertical_ctrl(vertical_ctrl), .horiz_ctrl(horiz_ctrl),
    .waste_ctrl(waste_ctrl), .bead_ctrl(bead_ctrl), .loop_exit_ctrl(loop_exit_ctrl),
    .bead_trap_ctrl(bead_trap_ctrl), .collect_ctrl(collect_ctrl), .pump(pump)
`ifdef MNACID_FLUSH_EN
    ,
    .lysis_flush(lysis_flush), .wash_flush(wash_flush), .elute_flush(elute_flush),
    .dead_end_flush(dead_end_flush), .vertical_flush(vertical_flush),
    .horiz_flush(horiz_flush), .waste_flush(waste_flush), .bead_flush(bead_flush),
    .loop_exit_flush(loop_exit_flush), .bead_trap_flush(bead_trap_flush),
    .collect_flush(collect_flush), .pump_flush(pump_flush)
`endif
  );

  // Bit order {collect,bead_trap,loop_exit,bead,waste,horiz,vertical,dead_end,elute,wash,lysis}.
  function automatic logic [10:0] exp_ctrl(int k);
    case (k)
      0: return 11'b111_0001_1111;
      1: return 11'b110_1010_1110;
      2: return 11'b111_1001_1101;
      3: return 11'b111_1110_0011;
      default: return 11'b000_1111_1111;
    endcase
  endfunction

  function automatic logic [2:0] exp_pat(int p);
    case (p)
      0: return 3'b110;
      1: return 3'b100;
      2: return 3'b101;
      3: return 3'b001;
      4: return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; n_samples = '0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ctrl_vec !== ALL_CLOSED || pump !== 3'b111 || busy !== 1'b0 || done !== 1'b0 || sample_idx !== 3'd0) begin
        errors++;
        $display("FAIL reset cycle %0d: ctrl=%b pump=%b busy=%b done=%b idx=%0d, want ctrl=%b pump=111 busy=0 done=0 idx=0",
                 i, ctrl_vec, pump, busy, done, sample_idx, ALL_CLOSED);
      end
    end
  endtask

  task automatic test_full_run();
    int cyc, s, w;
    logic [10:0] e_ctrl;
    logic [2:0]  e_pump, prev, e_idx;
    logic        e_busy, e_done;
    n_samples = 4'd2; start = 1'b1;
    tick();
    start = 1'b0; cyc = 1; prev = 3'b111;
    while (cyc <= 10*L + 4) begin
      // a start while busy must not disturb the run
      start = (cyc == 20);
      n_samples = (cyc == 20) ? 4'd5 : 4'd2;
      s = 0; w = 0;
      if (cyc <= 10*L) begin
        s = (cyc - 1) / L; w = (cyc - 1) % L;
        e_ctrl = exp_ctrl(s % 5);
        e_pump = (w < SETTLE || w >= PUMP_END) ? 3'b111 : exp_pat((w - SETTLE) / PUMP_HOLD);
        e_busy = 1'b1; e_done = 1'b0; e_idx = 3'(s / 5);
      end else begin
        e_ctrl = ALL_CLOSED; e_pump = 3'b111; e_busy = 1'b0; e_idx = 3'd0;
        e_done = (cyc == 10*L + 1);
      end
      checks++;
      if (ctrl_vec !== e_ctrl) begin
        errors++; $display("FAIL run ctrl @%0d: got %b want %b", cyc, ctrl_vec, e_ctrl);
      end
      checks++;
      if (pump !== e_pump) begin
        errors++; $display("FAIL run pump @%0d: got %b want %b", cyc, pump, e_pump);
      end
      checks++;
      if (busy !== e_busy || done !== e_done) begin
        errors++; $display("FAIL run busy/done @%0d: got %b/%b want %b/%b", cyc, busy, done, e_busy, e_done);
      end
      checks++;
      if (sample_idx !== e_idx) begin
        errors++; $display("FAIL run sample_idx @%0d: got %0d want %0d", cyc, sample_idx, e_idx);
      end
      if (cyc <= 10*L && w > SETTLE && w < PUMP_END) begin
        checks++;
        if ($countones(pump ^ prev) > 1) begin
          errors++; $display("FAIL pump onebit @%0d: %b -> %b", cyc, prev, pump);
        end
      end
`ifdef MNACID_FLUSH_EN
      checks++;
      if (cyc <= 10*L && w >= PUMP_END) begin
        if (flush_vec !== ~exp_ctrl(s % 5) || pump_flush !== 3'b111) begin
          errors++; $display("FAIL flush @%0d: got %b/%b want %b/111", cyc, flush_vec, pump_flush, ~exp_ctrl(s % 5));
        end
      end else if (flush_vec !== 11'd0 || pump_flush !== 3'b000) begin
        errors++; $display("FAIL flush idle @%0d: got %b/%b want 0/000", cyc, flush_vec, pump_flush);
      end
`endif
      prev = pump;
      tick();
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_pump_step();
    logic [2:0] tbl [14] = '{3'b111, 3'b111, 3'b110, 3'b110, 3'b100, 3'b100, 3'b101,
                             3'b101, 3'b001, 3'b001, 3'b011, 3'b011, 3'b010, 3'b010};
    n_samples = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (pump !== tbl[i]) begin
        errors++; $display("FAIL step pump[%0d]: got %b want %b", i, pump, tbl[i]);
      end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_abort();
    int cyc, got_cyc;
    n_samples = 4'd1; start = 1'b1;
    tick();
    start = 1'b0; cyc = 1;
    while (cyc < 3*L + 5) begin
      tick(); cyc++;
    end
    checks++;
    if (ctrl_vec !== exp_ctrl(3) || busy !== 1'b1) begin
      errors++; $display("FAIL abort pre: ctrl=%b busy=%b want %b busy=1", ctrl_vec, busy, exp_ctrl(3));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (ctrl_vec !== ALL_CLOSED || pump !== 3'b111 || busy !== 1'b0 || done !== 1'b0 || sample_idx !== 3'd0) begin
      errors++; $display("FAIL abort idle: ctrl=%b pump=%b busy=%b done=%b idx=%0d want all idle",
                         ctrl_vec, pump, busy, done, sample_idx);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL abort nodone %0d: done=%b busy=%b want 0/0", i, done, busy);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0; cyc = 1; got_cyc = -1;
    while (cyc <= 5*L + 10 && got_cyc < 0) begin
      if (done === 1'b1) got_cyc = cyc;
      else begin tick(); cyc++; end
    end
    checks++;
    if (got_cyc != 5*L + 1) begin
      errors++; $display("FAIL rerun done cycle: got %0d want %0d", got_cyc, 5*L + 1);
    end
    tick();
  endtask

  task automatic test_zero_and_clamp();
    int cyc, got_cyc;
    n_samples = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ctrl_vec !== ALL_CLOSED || pump !== 3'b111) begin
      errors++; $display("FAIL zero done: done=%b busy=%b ctrl=%b pump=%b want 1/0/%b/111", done, busy, ctrl_vec, pump, ALL_CLOSED);
    end
    tick();
    checks++;
    if (done !== 1'b0 || ctrl_vec !== ALL_CLOSED) begin
      errors++; $display("FAIL zero after: done=%b ctrl=%b want 0/%b", done, ctrl_vec, ALL_CLOSED);
    end
    n_samples = 4'd15; start = 1'b1;
    tick();
    start = 1'b0; cyc = 1; got_cyc = -1;
    while (cyc <= 40*L + 20 && got_cyc < 0) begin
      if (cyc == 35*L + 1) begin
        checks++;
        if (sample_idx !== 3'd7 || ctrl_vec !== exp_ctrl(0)) begin
          errors++; $display("FAIL clamp last sample: idx=%0d ctrl=%b want 7/%b", sample_idx, ctrl_vec, exp_ctrl(0));
        end
      end
      if (done === 1'b1) got_cyc = cyc;
      else begin tick(); cyc++; end
    end
    checks++;
    if (got_cyc != 40*L + 1) begin
      errors++; $display("FAIL clamp done cycle: got %0d want %0d", got_cyc, 40*L + 1);
    end
    tick();
  endtask

  task automatic test_start_abort_idle();
    n_samples = 4'd1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || ctrl_vec !== ALL_CLOSED) begin
        errors++; $display("FAIL start+abort %0d: busy=%b done=%b ctrl=%b want 0/0/%b", i, busy, done, ctrl_vec, ALL_CLOSED);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_pump_step();
    test_abort();
    test_zero_and_clamp();
    test_start_abort_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
